insight_hart_event_serializer: RTL
==================================

// Module: insight_hart_event_serializer
// PURPOSE
// - Upstream feeder of the hart-0 Insight trace channel (ready/valid/sink, 1-bit payload).
// - Captures WIDTH-bit hart event words, buffers them in a DEPTH-entry FIFO and
//   serializes each word onto the sink bit as a framed bitstream.
// - Counts events lost to FIFO overflow; event producers are never stalled.
// PARAMETERS
// - WIDTH  8   event word width, 2..32
// - DEPTH  4   FIFO entries, power of 2, >=2
// - CNT_W  16  drop counter width
// PORTS
// - clock           in   1      sole clock, rising edge
// - reset           in   1      asynchronous, active-high
// - ev_valid        in   1      event word present this cycle
// - ev_data         in   WIDTH  event word
// - enable          in   1      0: new events ignored (not counted as drops)
// - clear_overflow  in   1      clears overflow and drop_count
// - out_valid       out  1      sink bit valid (Insight valid)
// - out_ready       in   1      consumer accepts bit (Insight ready)
// - out_sink        out  1      serialized bit (Insight sink)
// - busy            out  1      FSM not IDLE or FIFO not empty
// - overflow        out  1      sticky: at least one event dropped
// - drop_count      out  CNT_W  dropped events, saturating
// BEHAVIOUR
// - Reset (async assert, sync-to-clock deassert not required here): FIFO empty,
//   FSM IDLE, out_valid=0, out_sink=0, busy=0, overflow=0, drop_count=0.
// - Push: ev_valid & enable & (count<DEPTH | load this cycle) -> word written.
//   ev_valid & enable & full & no load -> dropped: overflow<=1, drop_count+1,
//   saturates at 2^CNT_W-1. clear_overflow wins over a same-cycle drop.
// - Frame: start bit 1, then WIDTH data bits LSB first. Bit advances only on
//   out_valid & out_ready; out_valid/out_sink held stable while out_ready=0.
// - FSM: IDLE -> START when FIFO non-empty (pop = load into shift reg, same edge);
//   START -> DATA on accept; DATA -> DATA until bit WIDTH-1 accepted;
//   last data accept -> START if FIFO non-empty (back-to-back, no idle bubble),
//   else IDLE. out_valid=1 in START/DATA, 0 in IDLE.
// - Latency: event pushed at edge N -> pop/load at edge N+1 -> out_valid=1 from N+1
//   (start bit) when FSM was IDLE and FIFO was empty.
// - Simultaneous push to full FIFO and load: accepted, count stays DEPTH.
// - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
// - enable deassert mid-frame: current frame and queued words still drain.
// - Reset mid-frame: frame abandoned, no completion; consumer sees out_valid=0.
// CONFIGURATION
// - INSIGHT_EVENT_SER_PARITY_EN defined: one extra PARITY state after the last
//   data bit emits even parity of the word (XOR of data bits); frame = WIDTH+2 bits.
// - Undefined: no PARITY state, frame = WIDTH+1 bits; no parity logic built.
// TESTING
// - Reset, WIDTH=8, push 0xA5, out_ready=1 -> sink bits 1,1,0,1,0,0,1,0,1 on 9
//   consecutive cycles, then out_valid=0, busy=0.
// - Push 0x3C, hold out_ready=0 5 cycles after start -> out_valid=1, out_sink=1
//   stable; release -> frame completes unchanged.
// - DEPTH=4, out_ready=0, push 6 words -> 1 loaded + 4 queued, 1 drop:
//   overflow=1, drop_count=1; clear_overflow -> both 0.
// - Push 0x01 and 0xFF back-to-back, out_ready=1 -> 18 contiguous valid bits,
//   no bubble between frames.
// - Assert reset during data bit 3 -> out_valid=0 immediately, FIFO empty,
//   drop_count=0; next push 0x55 frames correctly.
// - PARITY_EN: push 0x07 -> 10-bit frame ending with parity bit 1; push 0x03 -> 0.

Source files
------------

// File: rtl/insight_hart_event_serializer.sv
// insight_hart_event_serializer
// Purpose : captures WIDTH-bit hart event words into a DEPTH-entry FIFO and
//           serializes each one onto the 1-bit Insight sink as a framed
//           bitstream: start bit 1, then the data bits LSB first.
// Latency : an event pushed at edge N is loaded at edge N+1, and the start bit
//           is valid from N+1 when the serializer was idle and the FIFO empty.
// Backpressure: the bit advances only on out_valid & out_ready, and
//           out_valid/out_sink hold steady while out_ready is low. Event
//           producers are never stalled. Events that arrive while the FIFO is
//           full are dropped and counted.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   ev_valid, ev_data     event word strobe and payload
//   enable                0: new events are ignored and not counted as drops
//   clear_overflow        clears overflow and drop_count
//   out_valid, out_ready  Insight valid/ready handshake for the sink bit
//   out_sink              serialized bit
//   busy                  FSM not idle, or FIFO holds words
//   overflow, drop_count  sticky drop flag and saturating drop counter
//
// Build option: define INSIGHT_EVENT_SER_PARITY_EN to append an even-parity bit
// (XOR of the data bits) after the last data bit. The frame is then WIDTH+2
// bits long instead of WIDTH+1.

module insight_hart_event_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ev_valid,
  input  logic [WIDTH-1:0] ev_data,
  input  logic             enable,
  input  logic             clear_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sink,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_DATA   = 2'd2,
    S_PARITY = 2'd3
  } state_t;

  // FIFO storage
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [WIDTH-1:0] head;

  // serializer state
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    bit_idx;

  // handshake and control
  logic             accept;
  logic             last_data;
  logic             frame_done;
  logic             load;
  logic             ev_take;
  logic             push;
  logic             drop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign head       = mem[rd_ptr];

  assign accept    = out_valid & out_ready;
  assign last_data = (state == S_DATA) && (bit_idx == IW'(WIDTH - 1));

`ifdef INSIGHT_EVENT_SER_PARITY_EN
  assign frame_done = accept && (state == S_PARITY);
`else
  assign frame_done = accept && last_data;
`endif

  // A word leaves the FIFO when the serializer is idle, or on the very edge
  // that completes the current frame. Loading on that edge is what makes
  // back-to-back frames contiguous.
  assign load = !fifo_empty && ((state == S_IDLE) || frame_done);

  // A full FIFO still accepts a word on an edge that also pops one, so the
  // occupancy stays at DEPTH and nothing is lost.
  assign ev_take = ev_valid & enable;
  assign push    = ev_take & (!fifo_full | load);
  assign drop    = ev_take & fifo_full & !load;

  assign busy = (state != S_IDLE) || !fifo_empty;

  // ---------------------------------------------------------------- FIFO
  // The storage array needs no reset because the pointers and the count
  // decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= ev_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, load})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
`ifdef INSIGHT_EVENT_SER_PARITY_EN
  logic par_bit;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_sink  <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
`ifdef INSIGHT_EVENT_SER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            shreg     <= head;
`ifdef INSIGHT_EVENT_SER_PARITY_EN
            par_bit   <= ^head;
`endif
            state     <= S_START;
            out_valid <= 1'b1;
            out_sink  <= 1'b1;
          end
        end

        S_START: begin
          if (accept) begin
            state    <= S_DATA;
            out_sink <= shreg[0];
            bit_idx  <= '0;
          end
        end

        S_DATA: begin
          if (accept) begin
            if (last_data) begin
`ifdef INSIGHT_EVENT_SER_PARITY_EN
              state    <= S_PARITY;
              out_sink <= par_bit;
`else
              if (load) begin
                shreg    <= head;
                state    <= S_START;
                out_sink <= 1'b1;
              end else begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
                out_sink  <= 1'b0;
              end
`endif
            end else begin
              // shreg[0] is on the wire now, so the next bit is shreg[1].
              shreg    <= shreg >> 1;
              out_sink <= shreg[1];
              bit_idx  <= bit_idx + IW'(1);
            end
          end
        end

`ifdef INSIGHT_EVENT_SER_PARITY_EN
        S_PARITY: begin
          if (accept) begin
            if (load) begin
              shreg     <= head;
              par_bit   <= ^head;
              state     <= S_START;
              out_sink  <= 1'b1;
            end else begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_sink  <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_sink  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- drops
  // When a clear and a drop land on the same edge, the clear takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule
